// File: rtl/rfid_pkg.sv
// Shared definitions for the reader-side frame logic.
//   frame_rd_state_t : state encoding of frame_bit_reader
//   hs_fire()        : valid/ready transfer qualifier used by the bit streams
package rfid_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLoad,
    StShift,
    StRewind,
    StCheck
  } frame_rd_state_t;

  // A beat transfers on a cycle where the producer is valid and the consumer ready.
  function automatic logic hs_fire(input logic valid, input logic ready);
    return valid & ready;
  endfunction

endpackage

// File: rtl/frame_bit_reader.sv
// frame_bit_reader: pops FRAME_WORDS words from a sync_fifo and serializes each word
// MSB-first onto a valid/ready bit stream. A retry rewinds the FIFO read pointer by the
// number of words popped in the current (or last) frame and replays them.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             begin a new frame (IDLE only)
//   retry             replay current/last frame (ignored in REWIND/CHECK or with no words)
//   fifo_empty        FIFO empty flag
//   fifo_rd_en        FIFO pop request
//   fifo_rd_data      FIFO read data, valid the cycle after fifo_rd_en
//   fifo_jump         one-cycle rewind request
//   fifo_jump_value   entries to rewind
//   fifo_jump_error   FIFO rejected the rewind (sampled in CHECK)
//   bit_out/bit_valid/bit_ready/bit_last   serialized bit stream
//   busy              not IDLE
//   done              one-cycle pulse after the final bit of a frame transfers
//   error             one-cycle pulse after a rejected rewind
module frame_bit_reader
  import rfid_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 12,
  parameter int unsigned ADDR_WIDTH  = 3,
  parameter int unsigned FRAME_WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  retry,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_jump,
  output logic [ADDR_WIDTH-1:0] fifo_jump_value,
  input  logic                  fifo_jump_error,
  output logic                  bit_out,
  output logic                  bit_valid,
  input  logic                  bit_ready,
  output logic                  bit_last,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned IdxW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IdxW-1:0]       IdxMax      = IdxW'(DATA_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] FrameWordsW = ADDR_WIDTH'(FRAME_WORDS);

  frame_rd_state_t       state_q, state_d;
  logic [ADDR_WIDTH-1:0] word_cnt_q, word_cnt_d;
  logic [IdxW-1:0]       bit_idx_q, bit_idx_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic                  retry_take;
  logic                  fire;

  // A retry with nothing popped has nothing to replay.
  assign retry_take = retry && (word_cnt_q != '0);
  assign fire       = hs_fire(bit_valid, bit_ready);

  always_comb begin
    state_d         = state_q;
    word_cnt_d      = word_cnt_q;
    bit_idx_d       = bit_idx_q;
    shreg_d         = shreg_q;
    done_d          = 1'b0;
    error_d         = 1'b0;
    fifo_rd_en      = 1'b0;
    fifo_jump       = 1'b0;
    fifo_jump_value = '0;
    bit_valid       = 1'b0;
    bit_out         = 1'b0;
    bit_last        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (retry_take) begin
          state_d = StRewind;
        end else if (start) begin
          word_cnt_d = '0;
          state_d    = StFetch;
        end
      end

      StFetch: begin
        if (retry_take) begin
          // No pop on a retry cycle, so the rewind distance stays equal to word_cnt.
          state_d = StRewind;
        end else if (!fifo_empty) begin
          fifo_rd_en = 1'b1;
          word_cnt_d = word_cnt_q + ADDR_WIDTH'(1);
          state_d    = StLoad;
        end
      end

      StLoad: begin
        if (retry_take) begin
          state_d = StRewind;
        end else begin
          shreg_d   = fifo_rd_data;
          bit_idx_d = IdxMax;
          state_d   = StShift;
        end
      end

      StShift: begin
        bit_valid = 1'b1;
        bit_out   = shreg_q[DATA_WIDTH-1];
        bit_last  = (bit_idx_q == '0) && (word_cnt_q == FrameWordsW);
        if (retry_take) begin
          // Retry beats a same-cycle transfer; that bit is treated as unsent.
          state_d = StRewind;
        end else if (fire) begin
          shreg_d = shreg_q << 1;
          if (bit_idx_q == '0) begin
            if (word_cnt_q < FrameWordsW) begin
              state_d = StFetch;
            end else begin
              done_d  = 1'b1;
              state_d = StIdle;
            end
          end else begin
            bit_idx_d = bit_idx_q - IdxW'(1);
          end
        end
      end

      StRewind: begin
        fifo_jump       = 1'b1;
        fifo_jump_value = word_cnt_q;
        shreg_d         = '0;
        bit_idx_d       = '0;
        state_d         = StCheck;
      end

      StCheck: begin
        word_cnt_d = '0;
        if (fifo_jump_error) begin
          error_d = 1'b1;
          state_d = StIdle;
        end else begin
          state_d = StFetch;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      word_cnt_q <= '0;
      bit_idx_q  <= '0;
      shreg_q    <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shreg_q    <= shreg_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign busy  = (state_q != StIdle);
  assign done  = done_q;
  assign error = error_q;

endmodule

// File: tb/tb_frame_bit_reader.sv
module tb_frame_bit_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        retry = 1'b0;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [11:0] fifo_rd_data = '0;
  logic        fifo_jump;
  logic [2:0]  fifo_jump_value;
  logic        fifo_jump_error = 1'b0;
  logic        bit_out, bit_valid, bit_last, busy, done, error;
  logic        bit_ready = 1'b1;

  int total = 0;
  int bad = 0;

  frame_bit_reader #(.DATA_WIDTH(12), .ADDR_WIDTH(3), .FRAME_WORDS(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .retry(retry), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .fifo_jump(fifo_jump),
    .fifo_jump_value(fifo_jump_value), .fifo_jump_error(fifo_jump_error),
    .bit_out(bit_out), .bit_valid(bit_valid), .bit_ready(bit_ready), .bit_last(bit_last),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural FIFO: depth 8, 4-bit pointers, registered read data, rewindable.
  logic [11:0] mem [8];
  logic [3:0]  wr_ptr = '0;
  logic [3:0]  rd_ptr = '0;
  logic        jerr_force = 1'b0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_rd_data <= mem[rd_ptr[2:0]];
      rd_ptr       <= rd_ptr + 4'd1;
    end else if (fifo_jump && !jerr_force) begin
      rd_ptr <= rd_ptr - 4'(fifo_jump_value);
    end
    fifo_jump_error <= fifo_jump ? jerr_force : 1'b0;
  end

  // Observation, sampled on the falling edge.
  bit cap_bits[$];
  bit exp_bits[$];
  int last_cnt, last_idx, last_cyc, rd_en_cnt, first_rd_cyc, first_valid_cyc;
  int jump_cnt, jump_cyc, done_cnt, done_cyc, done_busy_bad;
  int error_cnt, error_busy_bad, hold_viol, stall_cnt;
  logic [2:0] jump_val;
  bit prev_hold, prev_bit;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bit_valid && bit_ready && !retry) begin
        cap_bits.push_back(bit_out);
        if (bit_last) begin
          last_cnt++;
          last_idx = cap_bits.size() - 1;
          last_cyc = cyc;
        end
      end
      if (bit_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (fifo_rd_en) begin
        rd_en_cnt++;
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
      end
      if (fifo_jump) begin
        jump_cnt++;
        jump_val = fifo_jump_value;
        jump_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        if (busy) done_busy_bad++;
      end
      if (error) begin
        error_cnt++;
        if (busy) error_busy_bad++;
      end
      if (prev_hold && (!bit_valid || bit_out != prev_bit)) hold_viol++;
      if (bit_valid && !bit_ready) stall_cnt++;
      prev_hold = bit_valid && !bit_ready;
      prev_bit  = bit_out;
    end else begin
      prev_hold = 1'b0;
    end
  end

  task automatic clear_obs();
    cap_bits.delete();
    exp_bits.delete();
    last_cnt = 0; last_idx = -1; last_cyc = -1; rd_en_cnt = 0; first_rd_cyc = -1;
    first_valid_cyc = -1; jump_cnt = 0; jump_cyc = -1; jump_val = '0; done_cnt = 0;
    done_cyc = -1; done_busy_bad = 0; error_cnt = 0; error_busy_bad = 0; hold_viol = 0;
    stall_cnt = 0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [11:0] d);
    mem[wr_ptr[2:0]] = d;
    wr_ptr = wr_ptr + 4'd1;
  endtask

  task automatic add_exp(input logic [11:0] w);
    for (int b = 11; b >= 0; b--) exp_bits.push_back(w[b]);
  endtask

  function automatic int first_diff();
    if (cap_bits.size() != exp_bits.size()) return -2;
    foreach (cap_bits[i]) if (cap_bits[i] != exp_bits[i]) return i;
    return -1;
  endfunction

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      tick(1);
      n++;
    end
    tick(2);
    total++;
    if (done_cnt == 0) begin
      bad++;
      $display("FAIL %s_timeout: done seen=%0d required=1 within %0d cycles", name, done_cnt,
               budget);
    end
  endtask

  task automatic pulse(input bit is_retry);
    if (is_retry) retry = 1'b1; else start = 1'b1;
    tick(1);
    retry = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset();
    logic [10:0] outs;
    rst_n = 1'b0;
    tick(2);
    outs = {fifo_rd_en, fifo_jump, fifo_jump_value, bit_out, bit_valid, bit_last, busy,
            done, error};
    total++;
    if (outs !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got=%b required=0", outs);
    end
    rst_n = 1'b1;
    tick(3);
    outs = {fifo_rd_en, fifo_jump, fifo_jump_value, bit_out, bit_valid, bit_last, busy,
            done, error};
    total++;
    if (outs !== '0) begin
      bad++;
      $display("FAIL idle_outputs: got=%b required=0", outs);
    end
  endtask

  task automatic test_basic_frame();
    int k, d;
    logic [11:0] w0;
    clear_obs();
    for (int i = 1; i <= 4; i++) begin
      push(12'(i));
      add_exp(12'(i));
    end
    k = cyc;
    pulse(1'b0);
    wait_done("basic", 200);
    d = first_diff();
    total++;
    if (d != -1) begin
      bad++;
      $display("FAIL basic_stream: diff_at=%0d size=%0d required_size=48", d, cap_bits.size());
    end
    w0 = '0;
    for (int i = 0; i < 12 && i < cap_bits.size(); i++) w0 = {w0[10:0], cap_bits[i]};
    total++;
    if (w0 !== 12'h001) begin
      bad++;
      $display("FAIL basic_first_word: got=%h required=001", w0);
    end
    total++;
    if (last_cnt != 1 || last_idx != 47) begin
      bad++;
      $display("FAIL basic_bit_last: count=%0d idx=%0d required count=1 idx=47", last_cnt,
               last_idx);
    end
    total++;
    if (done_cnt != 1 || done_cyc != last_cyc + 1 || done_busy_bad != 0) begin
      bad++;
      $display("FAIL basic_done: count=%0d cyc=%0d last_cyc=%0d busy_bad=%0d required 1,last+1,0",
               done_cnt, done_cyc, last_cyc, done_busy_bad);
    end
    total++;
    if (rd_en_cnt != 4) begin
      bad++;
      $display("FAIL basic_rd_en_count: got=%0d required=4", rd_en_cnt);
    end
    total++;
    if (first_rd_cyc != k + 1 || first_valid_cyc != k + 3) begin
      bad++;
      $display("FAIL basic_latency: rd_en=%0d valid=%0d required %0d and %0d", first_rd_cyc,
               first_valid_cyc, k + 1, k + 3);
    end
  endtask

  task automatic test_retry_idle();
    int k, d;
    clear_obs();
    for (int i = 1; i <= 4; i++) add_exp(12'(i));
    k = cyc;
    pulse(1'b1);
    wait_done("retry_idle", 200);
    total++;
    if (jump_cnt != 1 || jump_val !== 3'd4 || jump_cyc != k + 1) begin
      bad++;
      $display("FAIL retry_idle_jump: count=%0d value=%0d cyc=%0d required 1,4,%0d", jump_cnt,
               jump_val, jump_cyc, k + 1);
    end
    total++;
    if (first_rd_cyc != k + 3) begin
      bad++;
      $display("FAIL retry_idle_refetch: got=%0d required=%0d", first_rd_cyc, k + 3);
    end
    d = first_diff();
    total++;
    if (d != -1) begin
      bad++;
      $display("FAIL retry_idle_stream: diff_at=%0d size=%0d required_size=48", d,
               cap_bits.size());
    end
  endtask

  task automatic test_retry_partial();
    int n, d;
    clear_obs();
    for (int i = 1; i <= 4; i++) push(12'(i));
    // 17 bits go out (word 1 plus 5 bits of word 2) before the retry.
    for (int i = 0; i < 17; i++) exp_bits.push_back((i == 11) ? 1'b1 : 1'b0);
    for (int i = 1; i <= 4; i++) add_exp(12'(i));
    pulse(1'b0);
    n = 0;
    while (cap_bits.size() < 17 && n < 100) begin
      tick(1);
      n++;
    end
    pulse(1'b1);
    wait_done("retry_partial", 300);
    total++;
    if (jump_cnt != 1 || jump_val !== 3'd2) begin
      bad++;
      $display("FAIL retry_partial_jump: count=%0d value=%0d required 1,2", jump_cnt, jump_val);
    end
    d = first_diff();
    total++;
    if (d != -1) begin
      bad++;
      $display("FAIL retry_partial_stream: diff_at=%0d size=%0d required_size=65", d,
               cap_bits.size());
    end
    total++;
    if (rd_en_cnt != 6) begin
      bad++;
      $display("FAIL retry_partial_rd_en: got=%0d required=6", rd_en_cnt);
    end
  endtask

  task automatic test_ready_toggle();
    int n, d;
    logic [11:0] words [4];
    words[0] = 12'hA5C; words[1] = 12'h3F0; words[2] = 12'h001; words[3] = 12'hFFE;
    clear_obs();
    for (int i = 0; i < 4; i++) begin
      push(words[i]);
      add_exp(words[i]);
    end
    pulse(1'b0);
    n = 0;
    while (done_cnt == 0 && n < 400) begin
      bit_ready = ~bit_ready;
      tick(1);
      n++;
    end
    bit_ready = 1'b1;
    tick(2);
    d = first_diff();
    total++;
    if (d != -1 || done_cnt != 1) begin
      bad++;
      $display("FAIL toggle_stream: diff_at=%0d size=%0d done=%0d required -1,48,1", d,
               cap_bits.size(), done_cnt);
    end
    total++;
    if (hold_viol != 0 || stall_cnt == 0) begin
      bad++;
      $display("FAIL toggle_hold: violations=%0d stalls=%0d required 0 and >0", hold_viol,
               stall_cnt);
    end
  endtask

  task automatic test_fifo_stall();
    int n, d;
    clear_obs();
    push(12'h123); push(12'h456);
    add_exp(12'h123); add_exp(12'h456); add_exp(12'h789); add_exp(12'hABC);
    pulse(1'b0);
    n = 0;
    while (cap_bits.size() < 24 && n < 100) begin
      tick(1);
      n++;
    end
    tick(10);
    total++;
    if (busy !== 1'b1 || bit_valid !== 1'b0 || fifo_rd_en !== 1'b0 || cap_bits.size() != 24)
    begin
      bad++;
      $display("FAIL stall_state: busy=%b valid=%b rd_en=%b bits=%0d required 1,0,0,24", busy,
               bit_valid, fifo_rd_en, cap_bits.size());
    end
    push(12'h789); push(12'hABC);
    wait_done("stall", 200);
    d = first_diff();
    total++;
    if (d != -1 || rd_en_cnt != 4) begin
      bad++;
      $display("FAIL stall_resume: diff_at=%0d rd_en=%0d required -1,4", d, rd_en_cnt);
    end
  endtask

  task automatic test_jump_error();
    int n;
    clear_obs();
    jerr_force = 1'b1;
    pulse(1'b1);
    n = 0;
    while (error_cnt == 0 && n < 20) begin
      tick(1);
      n++;
    end
    tick(3);
    jerr_force = 1'b0;
    total++;
    if (jump_cnt != 1 || jump_val !== 3'd4) begin
      bad++;
      $display("FAIL jerr_jump: count=%0d value=%0d required 1,4", jump_cnt, jump_val);
    end
    total++;
    if (error_cnt != 1 || error_busy_bad != 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL jerr_error: pulses=%0d busy_bad=%0d busy=%b required 1,0,0", error_cnt,
               error_busy_bad, busy);
    end
    total++;
    if (rd_en_cnt != 0 || done_cnt != 0) begin
      bad++;
      $display("FAIL jerr_no_fetch: rd_en=%0d done=%0d required 0,0", rd_en_cnt, done_cnt);
    end
    // word_cnt was cleared, so this retry has nothing to replay.
    pulse(1'b1);
    tick(6);
    total++;
    if (jump_cnt != 1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL jerr_retry_ignored: jumps=%0d busy=%b required 1,0", jump_cnt, busy);
    end
  endtask

  task automatic test_reset_mid_shift();
    int n;
    logic [10:0] outs;
    clear_obs();
    push(12'h800); push(12'h001); push(12'h002); push(12'h003);
    pulse(1'b0);
    n = 0;
    while (cap_bits.size() < 3 && n < 50) begin
      tick(1);
      n++;
    end
    total++;
    if (bit_valid !== 1'b1 || cap_bits.size() != 3 || cap_bits[0] != 1'b1) begin
      bad++;
      $display("FAIL midreset_pre: valid=%b bits=%0d required 1,3 first=1", bit_valid,
               cap_bits.size());
    end
    rst_n = 1'b0;
    #1;
    outs = {fifo_rd_en, fifo_jump, fifo_jump_value, bit_out, bit_valid, bit_last, busy,
            done, error};
    total++;
    if (outs !== '0) begin
      bad++;
      $display("FAIL midreset_outputs: got=%b required=0", outs);
    end
    tick(2);
    rst_n = 1'b1;
    tick(1);
    pulse(1'b1);
    tick(6);
    total++;
    if (jump_cnt != 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL midreset_retry_ignored: jumps=%0d busy=%b required 0,0", jump_cnt, busy);
    end
  endtask

  initial begin
    clear_obs();
    test_reset();
    test_basic_frame();
    test_retry_idle();
    test_retry_partial();
    test_ready_toggle();
    test_fifo_stall();
    test_jump_error();
    test_reset_mid_shift();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
